// File: rtl/endpreg_multi.sv
// endpreg_multi: left/right endpoint register pair with an optional undo history.
// The ztonxor operand either loads or is XORed into qL or qR. SWAP exchanges the
// two registers, and CLEAR zeroes both. ltorxor is the combinational XOR of the pair.
// Define ENDPREG_UNDO_EN to build in the DEPTH-entry undo history. Without that
// macro, inst 111 acts as NOP and hist_count and err are tied to zero.
module endpreg_multi #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   inst,
    input  logic [WIDTH-1:0]             ztonxor,
    output logic [WIDTH-1:0]             qL,
    output logic [WIDTH-1:0]             qR,
    output logic [WIDTH-1:0]             ltorxor,
    output logic [$clog2(DEPTH+1)-1:0]   hist_count,
    output logic                         err
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_CLEAR = 3'b001;
    localparam logic [2:0] OP_LOADL = 3'b010;
    localparam logic [2:0] OP_LOADR = 3'b011;
    localparam logic [2:0] OP_XORL  = 3'b100;
    localparam logic [2:0] OP_XORR  = 3'b101;
    localparam logic [2:0] OP_SWAP  = 3'b110;
    localparam logic [2:0] OP_UNDO  = 3'b111;

    logic [WIDTH-1:0] next_l;
    logic [WIDTH-1:0] next_r;
    logic             is_push;

    assign ltorxor = qL ^ qR;

`ifdef ENDPREG_UNDO_EN
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // wr_ptr always points at the slot the next push will fill.
    // The newest entry is therefore one slot behind wr_ptr.
    logic [2*WIDTH-1:0] hist_mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      pop_idx;
    logic [PW-1:0]      push_idx;
    logic               is_pop;
    logic               is_illegal;

    // Pointer arithmetic that wraps around the DEPTH-entry ring.
    always_comb begin
        pop_idx  = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
        push_idx = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
`endif

    // Decode the opcode into the next register values and any history action.
    always_comb begin
        next_l  = qL;
        next_r  = qR;
        is_push = 1'b0;
`ifdef ENDPREG_UNDO_EN
        is_pop     = 1'b0;
        is_illegal = 1'b0;
`endif
        case (inst)
            OP_NOP: ;
            OP_CLEAR: begin
                next_l  = '0;
                next_r  = '0;
                is_push = 1'b1;
            end
            OP_LOADL: begin
                next_l  = ztonxor;
                is_push = 1'b1;
            end
            OP_LOADR: begin
                next_r  = ztonxor;
                is_push = 1'b1;
            end
            OP_XORL: begin
                next_l  = qL ^ ztonxor;
                is_push = 1'b1;
            end
            OP_XORR: begin
                next_r  = qR ^ ztonxor;
                is_push = 1'b1;
            end
            OP_SWAP: begin
                next_l  = qR;
                next_r  = qL;
                is_push = 1'b1;
            end
`ifdef ENDPREG_UNDO_EN
            OP_UNDO: begin
                if (hist_count != '0) begin
                    next_l = hist_mem[pop_idx][2*WIDTH-1:WIDTH];
                    next_r = hist_mem[pop_idx][WIDTH-1:0];
                    is_pop = 1'b1;
                end else begin
                    is_illegal = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Endpoint registers. Reset wins over any opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            qL <= '0;
            qR <= '0;
        end else begin
            qL <= next_l;
            qR <= next_r;
        end
    end

`ifdef ENDPREG_UNDO_EN
    // History bookkeeping. A full ring overwrites its oldest entry and keeps the count.
    // A pop rewinds wr_ptr, so the next push reuses the slot that was just popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            hist_count <= '0;
            err        <= 1'b0;
        end else begin
            err <= is_illegal;
            if (is_push) begin
                wr_ptr <= push_idx;
                if (hist_count != CW'(DEPTH)) begin
                    hist_count <= hist_count + 1'b1;
                end
            end else if (is_pop) begin
                wr_ptr     <= pop_idx;
                hist_count <= hist_count - 1'b1;
            end
        end
    end

    // History storage holds the pre-operation pair. It has no reset, because
    // clearing the pointers is enough to make old entries unreachable.
    always_ff @(posedge clk) begin
        if (!reset && is_push) begin
            hist_mem[wr_ptr] <= {qL, qR};
        end
    end
`else
    assign hist_count = '0;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_endpreg_multi.sv
// Self-checking bench for endpreg_multi with WIDTH=4 and DEPTH=2.
// Expected values are selected by ENDPREG_UNDO_EN, so the bench matches the RTL build.
module tb_endpreg_multi;

    logic       clk;
    logic       reset;
    logic [2:0] inst;
    logic [3:0] ztonxor;
    logic [3:0] qL;
    logic [3:0] qR;
    logic [3:0] ltorxor;
    logic [1:0] hist_count;
    logic       err;

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic [3:0] z;
        logic [3:0] exp_l;
        logic [3:0] exp_r;
        logic [1:0] exp_h;
        logic       exp_e;
    } vec_t;

    vec_t vecs[$];

    endpreg_multi #(.WIDTH(4), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst       (inst),
        .ztonxor    (ztonxor),
        .qL         (qL),
        .qR         (qR),
        .ltorxor    (ltorxor),
        .hist_count (hist_count),
        .err        (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void addVec(logic rst, logic [2:0] op, logic [3:0] z,
                                   logic [3:0] el, logic [3:0] er, logic [1:0] eh, logic ee);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z;
        v.exp_l = el; v.exp_r = er; v.exp_h = eh; v.exp_e = ee;
        vecs.push_back(v);
    endfunction

    // Drive on the falling edge and let one rising edge sample it. Then step
    // just past that edge so the outputs can be read safely.
    task automatic applyStimulus(input logic rst, input logic [2:0] op, input logic [3:0] z);
        @(negedge clk);
        reset   = rst;
        inst    = op;
        ztonxor = z;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input int idx, input logic [3:0] el, input logic [3:0] er,
                               input logic [1:0] eh, input logic ee);
        checkOne("qL", idx, qL, el);
        checkOne("qR", idx, qR, er);
        checkOne("ltorxor", idx, ltorxor, el ^ er);
        checkOne("hist_count", idx, {2'b00, hist_count}, {2'b00, eh});
        checkOne("err", idx, {3'b000, err}, {3'b000, ee});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        inst     = 3'b000;
        ztonxor  = 4'h0;

`ifdef ENDPREG_UNDO_EN
        //     rst  op      z     qL    qR    hist err
        addVec(1, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0, 0);   // reset
        addVec(0, 3'b010, 4'hA, 4'hA, 4'h0, 2'd1, 0);   // LOADL A
        addVec(0, 3'b011, 4'h3, 4'hA, 4'h3, 2'd2, 0);   // LOADR 3
        addVec(0, 3'b100, 4'hF, 4'h5, 4'h3, 2'd2, 0);   // XORL F, oldest dropped
        addVec(0, 3'b110, 4'h0, 4'h3, 4'h5, 2'd2, 0);   // SWAP
        addVec(0, 3'b111, 4'h0, 4'h5, 4'h3, 2'd1, 0);   // UNDO
        addVec(0, 3'b111, 4'h0, 4'hA, 4'h3, 2'd0, 0);   // UNDO
        addVec(0, 3'b111, 4'h0, 4'hA, 4'h3, 2'd0, 1);   // illegal UNDO
        addVec(0, 3'b000, 4'h7, 4'hA, 4'h3, 2'd0, 0);   // NOP, err drops
        addVec(0, 3'b111, 4'h0, 4'hA, 4'h3, 2'd0, 1);   // illegal UNDO
        addVec(0, 3'b111, 4'h0, 4'hA, 4'h3, 2'd0, 1);   // illegal UNDO back to back
        addVec(0, 3'b000, 4'h0, 4'hA, 4'h3, 2'd0, 0);
        addVec(1, 3'b011, 4'hF, 4'h0, 4'h0, 2'd0, 0);   // reset beats LOADR
        addVec(0, 3'b010, 4'h6, 4'h6, 4'h0, 2'd1, 0);   // LOADL 6
        addVec(0, 3'b111, 4'h0, 4'h0, 4'h0, 2'd0, 0);   // UNDO
        addVec(0, 3'b011, 4'h9, 4'h0, 4'h9, 2'd1, 0);   // LOADR 9 overwrites popped slot
        addVec(0, 3'b111, 4'h0, 4'h0, 4'h0, 2'd0, 0);   // UNDO restores {0,0}
        addVec(0, 3'b010, 4'h1, 4'h1, 4'h0, 2'd1, 0);
        addVec(0, 3'b011, 4'h2, 4'h1, 4'h2, 2'd2, 0);
        addVec(1, 3'b111, 4'h0, 4'h0, 4'h0, 2'd0, 0);   // reset during UNDO
        addVec(0, 3'b111, 4'h0, 4'h0, 4'h0, 2'd0, 1);   // history gone
        addVec(0, 3'b001, 4'h0, 4'h0, 4'h0, 2'd1, 0);   // CLEAR still pushes
        addVec(0, 3'b101, 4'h7, 4'h0, 4'h7, 2'd2, 0);   // XORR 7
        addVec(0, 3'b110, 4'h0, 4'h7, 4'h0, 2'd2, 0);   // SWAP
        addVec(0, 3'b111, 4'h0, 4'h0, 4'h7, 2'd1, 0);
        addVec(0, 3'b000, 4'hF, 4'h0, 4'h7, 2'd1, 0);   // NOP leaves history
        addVec(0, 3'b111, 4'h0, 4'h0, 4'h0, 2'd0, 0);
`else
        addVec(1, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0, 0);   // reset
        addVec(0, 3'b010, 4'h5, 4'h5, 4'h0, 2'd0, 0);   // LOADL 5
        addVec(0, 3'b111, 4'h0, 4'h5, 4'h0, 2'd0, 0);   // UNDO acts as NOP
        addVec(0, 3'b011, 4'h3, 4'h5, 4'h3, 2'd0, 0);
        addVec(0, 3'b100, 4'hF, 4'hA, 4'h3, 2'd0, 0);
        addVec(0, 3'b101, 4'h6, 4'hA, 4'h5, 2'd0, 0);
        addVec(0, 3'b110, 4'h0, 4'h5, 4'hA, 2'd0, 0);
        addVec(0, 3'b000, 4'hF, 4'h5, 4'hA, 2'd0, 0);
        addVec(0, 3'b111, 4'hC, 4'h5, 4'hA, 2'd0, 0);
        addVec(0, 3'b001, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        addVec(0, 3'b010, 4'h9, 4'h9, 4'h0, 2'd0, 0);
        addVec(1, 3'b010, 4'h3, 4'h0, 4'h0, 2'd0, 0);   // reset beats LOADL
        addVec(0, 3'b011, 4'hC, 4'h0, 4'hC, 2'd0, 0);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].z);
            checkOutput(i, vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_h, vecs[i].exp_e);
        end

        // Reset held over several edges with a live opcode, then first edge after release.
        applyStimulus(0, 3'b011, 4'hB);
        applyStimulus(1, 3'b010, 4'hF);
        applyStimulus(1, 3'b010, 4'hF);
        checkOutput(100, 4'h0, 4'h0, 2'd0, 1'b0);
        applyStimulus(0, 3'b010, 4'hF);
`ifdef ENDPREG_UNDO_EN
        checkOutput(101, 4'hF, 4'h0, 2'd1, 1'b0);
        applyStimulus(0, 3'b100, 4'hF);                 // same-value-changing op still pushes
        applyStimulus(0, 3'b000, 4'h0);
        checkOutput(102, 4'h0, 4'h0, 2'd2, 1'b0);
        applyStimulus(0, 3'b111, 4'h0);
        checkOutput(103, 4'hF, 4'h0, 2'd1, 1'b0);
`else
        checkOutput(101, 4'hF, 4'h0, 2'd0, 1'b0);
        applyStimulus(0, 3'b111, 4'h0);
        checkOutput(102, 4'hF, 4'h0, 2'd0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/endpreg_multi.md
ENDPREG_MULTI -- requirements
Module: endpreg_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 4: lane width of the ztonxor, qL, qR and ltorxor datapath.
REQ-002 SHALL have parameter DEPTH, default 4, legal range 2..16: number of entries in the undo history.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port inst, input, 3 bits: operation code, sampled every cycle.
REQ-006 SHALL have port ztonxor, input, WIDTH bits: operand from the neighbouring cell.
REQ-007 SHALL have port qL, output, WIDTH bits: left endpoint register.
REQ-008 SHALL have port qR, output, WIDTH bits: right endpoint register.
REQ-009 SHALL have port ltorxor, output, WIDTH bits: combinational qL ^ qR.
REQ-010 SHALL have port hist_count, output, $clog2(DEPTH+1) bits: number of valid undo entries.
REQ-011 SHALL have port err, output, 1 bit: registered one-cycle pulse on an illegal UNDO.

Function
REQ-012 SHALL decode inst as: 000 NOP (hold), 001 CLEAR (qL=qR=0), 010 LOADL (qL=ztonxor), 011 LOADR (qR=ztonxor), 100 XORL (qL=qL^ztonxor), 101 XORR (qR=qR^ztonxor), 110 SWAP (qL<->qR), 111 UNDO.
REQ-013 SHALL update qL/qR at the rising edge in which inst is sampled; result is visible one cycle after sampling (latency 1).
REQ-014 SHALL push the pre-operation {qL,qR} onto the history for every inst 001..110, including when the operation leaves the value unchanged.
REQ-015 SHALL, when a push occurs with hist_count==DEPTH, discard the oldest entry, store the new one, and keep hist_count at DEPTH (circular overwrite, no error).
REQ-016 SHALL, on UNDO with hist_count>0, restore {qL,qR} from the newest entry and decrement hist_count by 1 in the same edge.
REQ-017 SHALL, on UNDO with hist_count==0, hold qL/qR, hold hist_count at 0, and assert err for exactly the following cycle.
REQ-018 SHALL hold err at 0 in every cycle not following an illegal UNDO; back-to-back illegal UNDOs produce err high for consecutive cycles.
REQ-019 SHALL make NOP touch neither qL/qR nor the history.
REQ-020 SHALL keep the history as a DEPTH-entry circular buffer with wrap-around read/write pointers; push-after-undo overwrites the entry just popped.

Reset
REQ-021 SHALL, while reset is high at a rising edge, set qL=0, qR=0, hist_count=0, err=0, and clear the history pointers, ignoring inst.
REQ-022 SHALL give reset priority over any inst, including mid-sequence UNDO; entries pushed before reset are unrecoverable afterwards.
REQ-023 SHALL resume normal decode on the first rising edge with reset low.

Configuration
REQ-024 SHALL compile in the undo history only when macro ENDPREG_UNDO_EN is defined.
REQ-025 SHALL, with ENDPREG_UNDO_EN defined, behave per REQ-014..REQ-020.
REQ-026 SHALL, without ENDPREG_UNDO_EN, implement no history storage, treat inst 111 as NOP, tie hist_count to 0 and err to 0, keep every port present, and leave opcodes 000..110 unchanged.

Verification (WIDTH=4, DEPTH=2, ENDPREG_UNDO_EN defined unless stated)
REQ-027 SHALL cover: reset 1 cycle, then LOADL 0xA, LOADR 0x3 -> qL=0xA, qR=0x3, ltorxor=0x9, hist_count=2.
REQ-028 SHALL cover: from REQ-027 state, XORL 0xF then SWAP -> qL=0x3, qR=0x5, hist_count=2 (oldest dropped); UNDO -> qL=0x5, qR=0x3; UNDO -> qL=0xA, qR=0x3; hist_count=0.
REQ-029 SHALL cover: UNDO with hist_count=0 -> qL/qR unchanged, err=1 for one cycle, then 0; two consecutive illegal UNDOs -> err=1 for two cycles.
REQ-030 SHALL cover: LOADL 0x6, UNDO, LOADR 0x9 -> qL=0x0, qR=0x9, hist_count=1, the undone entry overwritten.
REQ-031 SHALL cover: reset asserted for one cycle with hist_count=2 and inst=UNDO -> qL=qR=0, hist_count=0, err=0; a following UNDO -> err=1.
REQ-032 SHALL cover: build without ENDPREG_UNDO_EN, LOADL 0x5 then UNDO -> qL=0x5, err=0, hist_count=0.
